vid_pattern_gen: RTL and testbench
==================================

# vid_pattern_gen

Upstream source stage for the video path: generates 1080p raster timing (`fvht`) and a matching 10-bit 4:2:2 test pattern, and feeds the `fvht_i` / `vdat_bars_i` inputs of the overlay stage that draws the bouncing box. The raster advances only on clock-enabled cycles. Outputs are registered and mutually aligned, so the downstream stage can delay them together.

## Interface
- `H_ACTIVE`, 1920: active samples per line
- `H_TOTAL`, 2200: total samples per line; must be > `H_ACTIVE`
- `V_ACTIVE`, 1080: active lines per frame
- `V_TOTAL`, 1125: total lines per frame; must be > `V_ACTIVE`
- `clk_i` input 1: clock; the block uses only this one clock
- `rst_n_i` input 1: reset, asynchronous assert, active-low
- `cen_i` input 1: clock enable; all state advances only when high
- `run_i` input 1: 1 = raster free-runs; 0 = counters freeze at the next frame start
- `pat_sel_i` input 1: pattern select, 0 = colour bars, 1 = luma ramp (see Configuration)
- `fvht_o` output 4: {F, V, H, T} timing flags
- `video_o` output 20: {luma[19:10], chroma[9:0]}
- `frame_cnt_o` output 8: frames completed, wraps 255 -> 0

## Operation
- `h_cnt` counts 0..`H_TOTAL`-1. Active region is `h_cnt` < `H_ACTIVE`. Wraps to 0 and increments `v_cnt`.
- `v_cnt` counts 0..`V_TOTAL`-1. Active region is `v_cnt` < `V_ACTIVE`. Wraps to 0 at the end of the last line, and `frame_cnt_o` increments at that point.
- Flags:
  - F = 0 always (progressive).
  - V = 1 when `v_cnt` >= `V_ACTIVE`.
  - H = 1 when `h_cnt` >= `H_ACTIVE`.
  - T = 1 only when `h_cnt` = 0 and `v_cnt` = 0 (frame start marker, one sample wide).
- Blanking (H or V high): `video_o` = {10'h040, 10'h200}.
- Chroma is sited on the sample: Cb when `h_cnt[0]` = 0, Cr when `h_cnt[0]` = 1.
- Colour bars:
  - 8 bars, each `H_ACTIVE`/8 samples wide.
  - Bar index comes from a bar-width sub-counter; no divider.
  - 75% levels, as {Y, Cb, Cr}: white 721/512/512, yellow 674/176/543, cyan 581/589/176, green 534/253/207, magenta 251/771/817, red 204/435/848, blue 111/848/481, black 64/512/512.
- `run_i` behaviour:
  - When `run_i` is low at the cycle where `h_cnt` = `v_cnt` = 0, counters hold there and the output repeats that sample's flags (T = 1, active first bar).
  - Counting resumes on the first cen cycle with `run_i` high.
  - Mid-frame deassertion of `run_i` takes effect only at the next frame start.
- `pat_sel_i` is sampled only at frame start, so a frame never changes pattern partway through.

## Timing
- Reset values:
  - counters = 0
  - `fvht_o` = 4'b0000
  - `video_o` = {10'h040, 10'h200}
  - `frame_cnt_o` = 0
  - latched pattern select = bars
- Latency: `fvht_o` and `video_o` reflect counter state from the previous enabled cycle (1 cen cycle). Both come from the same register stage.
- `cen_i` low: every register holds, outputs included.
- Reset mid-frame: async clear to the reset values; the first enabled cycle after release outputs the frame-start sample.
- Frame period at `run_i` = 1 is exactly `H_TOTAL` × `V_TOTAL` enabled cycles.

## Configuration
- Macro `VID_PATGEN_RAMP_EN`.
- Defined:
  - `pat_sel_i` = 1 selects the luma ramp: Y = 64 + (`h_cnt` × 876 / `H_ACTIVE`), computed by an accumulator rather than a multiplier.
  - Chroma = 512.
  - Ramp reaches 939 at most.
- Undefined:
  - `pat_sel_i` is ignored and the port remains.
  - Bars only; no ramp logic is synthesised.

## Structure
- Package `vid_pkg`:
  - `fvht` bit-index constants (F = 3, V = 2, H = 1, T = 0)
  - blank levels
  - `ycbcr_t` struct {y, cb, cr}, 10 bits each
  - the 8-entry bar colour constant array
- Sub-module `vid_timing_cnt`: owns `h_cnt`, `v_cnt`, the `run_i` freeze and the frame counter, and exports counts and raw flags.
- `vid_pattern_gen` owns pattern generation and the output register.

## Test plan
- Reset then `cen_i` = 1, `run_i` = 1:
  - first output has `fvht_o` = 4'b0001 and `video_o` = {721, 512}
  - after 1920 samples H = 1
  - after 2200 samples the next line starts
- Full frame:
  - T pulses once every 2,475,000 enabled cycles
  - V = 1 on lines 1080..1124
  - `frame_cnt_o` goes 0 -> 1 -> 2
- Bar edges, line 0:
  - sample 239 is white Cr (512); sample 240 is yellow Cb (176)
  - sample 1919 is black Cr (512)
  - sample 1920 is blank {64, 512}
- `cen_i` toggled 1-of-3:
  - the output sequence is identical to the continuous run, stretched by 3
  - outputs hold while `cen_i` is low
- `run_i` dropped at line 500:
  - the raster completes the frame, then holds at the T = 1 sample
  - raising `run_i` resumes at `h_cnt` = 1
- With `VID_PATGEN_RAMP_EN`, `pat_sel_i` = 1 set mid-frame:
  - the ramp appears only from the next frame
  - luma at sample 0 is 64, and is ≤ 939 at sample 1919
- Async reset pulsed mid-line: all outputs are at reset values within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared video constants and types: fvht bit positions, blank levels and the
// 75% colour-bar table used by vid_pattern_gen.
package vid_pkg;

  localparam int F_BIT = 3;
  localparam int V_BIT = 2;
  localparam int H_BIT = 1;
  localparam int T_BIT = 0;

  localparam logic [9:0] Y_BLANK    = 10'h040;
  localparam logic [9:0] C_BLANK    = 10'h200;
  localparam logic [9:0] Y_RAMP_MAX = 10'd939;
  localparam int         RAMP_SPAN  = 876;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } ycbcr_t;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black
  localparam ycbcr_t BAR_LUT [8] = '{
    '{10'd721, 10'd512, 10'd512},
    '{10'd674, 10'd176, 10'd543},
    '{10'd581, 10'd589, 10'd176},
    '{10'd534, 10'd253, 10'd207},
    '{10'd251, 10'd771, 10'd817},
    '{10'd204, 10'd435, 10'd848},
    '{10'd111, 10'd848, 10'd481},
    '{10'd64,  10'd512, 10'd512}
  };

endpackage

// File: rtl/vid_timing_cnt.sv
// Raster position counters with the run_i freeze at frame start, the completed
// frame count, and the raw {F,V,H,T} flags for the current position.
module vid_timing_cnt
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1125,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cen_i,
  input  logic          run_i,
  output logic [HW-1:0] h_cnt,
  output logic          frame_start,
  output logic          step,
  output logic [3:0]    fvht_raw,
  output logic [7:0]    frame_cnt
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

  logic [VW-1:0] v_cnt;

  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  // Freezing only at frame start lets a frame already under way run to completion.
  assign step = cen_i && (run_i || !frame_start);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (step) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    fvht_raw        = '0;
    fvht_raw[V_BIT] = (v_cnt >= V_ACT);
    fvht_raw[H_BIT] = (h_cnt >= H_ACT);
    fvht_raw[T_BIT] = frame_start;
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// 1080p raster source with 10-bit 4:2:2 colour bars; defining VID_PATGEN_RAMP_EN
// adds a luma ramp selected per frame by pat_sel_i. All outputs share one register stage.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1125
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cen_i,
  input  logic        run_i,
  input  logic        pat_sel_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] video_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [HW-1:0] h_cnt;
  logic          frame_start;
  logic          step;
  logic          line_end;
  logic [3:0]    fvht_raw;
  logic [7:0]    frame_cnt;
  logic [BW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  ycbcr_t        bar_pix;
  logic [9:0]    luma;
  logic [9:0]    chroma;

  vid_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .HW       (HW)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cen_i       (cen_i),
    .run_i       (run_i),
    .h_cnt       (h_cnt),
    .frame_start (frame_start),
    .step        (step),
    .fvht_raw    (fvht_raw),
    .frame_cnt   (frame_cnt)
  );

  assign line_end = (h_cnt == H_LAST);

  // Bar index follows h_cnt via a per-bar sample counter; it parks on the last bar through blanking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (step) begin
      if (line_end) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end
    end
  end

`ifdef VID_PATGEN_RAMP_EN
  localparam int AW = $clog2(H_ACTIVE + RAMP_SPAN);
  localparam logic [AW-1:0] ACC_STEP = AW'(RAMP_SPAN);
  localparam logic [AW-1:0] ACC_WRAP = AW'(H_ACTIVE);

  logic [AW-1:0] ramp_acc;
  logic [AW-1:0] acc_sum;
  logic [9:0]    ramp_y;
  logic          sel_q;
  logic          sel_eff;

  assign acc_sum = ramp_acc + ACC_STEP;
  assign sel_eff = frame_start ? pat_sel_i : sel_q;

  // ramp_acc is the remainder of h_cnt*RAMP_SPAN/H_ACTIVE; each wrap bumps luma by one code.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ramp_acc <= '0;
      ramp_y   <= Y_BLANK;
      sel_q    <= 1'b0;
    end else if (cen_i) begin
      if (frame_start) sel_q <= pat_sel_i;
      if (step) begin
        if (line_end) begin
          ramp_acc <= '0;
          ramp_y   <= Y_BLANK;
        end else if (acc_sum >= ACC_WRAP) begin
          ramp_acc <= acc_sum - ACC_WRAP;
          if (ramp_y != Y_RAMP_MAX) ramp_y <= ramp_y + 10'd1;
        end else begin
          ramp_acc <= acc_sum;
        end
      end
    end
  end
`else
  logic unused_pat_sel;
  assign unused_pat_sel = pat_sel_i;
`endif

  assign bar_pix = BAR_LUT[bar_idx];

  always_comb begin
    luma   = bar_pix.y;
    chroma = h_cnt[0] ? bar_pix.cr : bar_pix.cb;
`ifdef VID_PATGEN_RAMP_EN
    if (sel_eff) begin
      luma   = ramp_y;
      chroma = C_BLANK;
    end
`endif
    if (fvht_raw[H_BIT] || fvht_raw[V_BIT]) begin
      luma   = Y_BLANK;
      chroma = C_BLANK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fvht_o      <= '0;
      video_o     <= {Y_BLANK, C_BLANK};
      frame_cnt_o <= '0;
    end else if (cen_i) begin
      fvht_o      <= fvht_raw;
      video_o     <= {luma, chroma};
      frame_cnt_o <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Scoreboard bench for vid_pattern_gen on a 1920x3 active raster (2200x4 total)
// so that whole frames stay short.
module tb_vid_pattern_gen;

  localparam int H_A   = 1920;
  localparam int H_T   = 2200;
  localparam int V_A   = 3;
  localparam int V_T   = 4;
  localparam int LIMIT = 20000;

  localparam int BAR_Y  [8] = '{721, 674, 581, 534, 251, 204, 111, 64};
  localparam int BAR_CB [8] = '{512, 176, 589, 253, 771, 435, 848, 512};
  localparam int BAR_CR [8] = '{512, 543, 176, 207, 817, 848, 481, 512};
  localparam logic [31:0] RST_OUT = {8'd0, 4'b0000, 10'h040, 10'h200};

`ifdef VID_PATGEN_RAMP_EN
  localparam bit RAMP_BUILD = 1'b1;
`else
  localparam bit RAMP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        run;
  logic        pat_sel;
  logic [3:0]  fvht;
  logic [19:0] video;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  int          m_h;
  int          m_v;
  int          m_frame;
  bit          m_sel;
  logic [31:0] m_out;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  vid_pattern_gen #(
    .H_ACTIVE (H_A),
    .H_TOTAL  (H_T),
    .V_ACTIVE (V_A),
    .V_TOTAL  (V_T)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cen_i       (cen),
    .run_i       (run),
    .pat_sel_i   (pat_sel),
    .fvht_o      (fvht),
    .video_o     (video),
    .frame_cnt_o (frame_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int y, input int c);
    return 32'(y * 1024 + c);
  endfunction

  function automatic logic [31:0] expSample(input int h, input int v, input int fr, input bit ramp);
    int         y;
    int         c;
    int         idx;
    logic [3:0] fl;
    fl = {1'b0, (v >= V_A), (h >= H_A), (h == 0 && v == 0)};
    if (v >= V_A || h >= H_A) begin
      y = 64;
      c = 512;
    end else if (ramp) begin
      y = 64 + (h * 876) / H_A;
      c = 512;
    end else begin
      idx = h / (H_A / 8);
      y   = BAR_Y[idx];
      c   = (h % 2 == 1) ? BAR_CR[idx] : BAR_CB[idx];
    end
    return {fr[7:0], fl, y[9:0], c[9:0]};
  endfunction

  task automatic resetModel();
    m_h     = 0;
    m_v     = 0;
    m_frame = 0;
    m_sel   = 1'b0;
    m_out   = RST_OUT;
    sb.delete();
  endtask

  task automatic modelStep(input bit c, input bit r, input bit s);
    bit fs;
    bit sel_eff;
    fs      = (m_h == 0 && m_v == 0);
    sel_eff = fs ? s : m_sel;
    if (c) begin
      m_out = expSample(m_h, m_v, m_frame, RAMP_BUILD && sel_eff);
      if (fs) m_sel = s;
      if (r || !fs) begin
        if (m_h == H_T - 1) begin
          m_h = 0;
          if (m_v == V_T - 1) begin
            m_v     = 0;
            m_frame = (m_frame + 1) % 256;
          end else begin
            m_v++;
          end
        end else begin
          m_h++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit c, input bit r, input bit s);
    @(negedge clk);
    cen     = c;
    run     = r;
    pat_sel = s;
    modelStep(c, r, s);
    sb.push_back(m_out);
    @(posedge clk);
    #1;
    checkOutput("out", {frame_cnt, fvht, video}, sb.pop_front());
  endtask

  initial begin
    int n;
    int vcount;
    rst_n   = 1'b0;
    cen     = 1'b0;
    run     = 1'b1;
    pat_sel = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_fvht", 32'(fvht), 32'h0);
    checkOutput("rst_video", 32'(video), pix(64, 512));
    checkOutput("rst_frame", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] line 0 and bar edges");
    for (int k = 0; k <= H_T; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (k == 0) begin
        checkOutput("first_fvht", 32'(fvht), 32'h1);
        checkOutput("first_video", 32'(video), pix(721, 512));
      end
      if (k == 239)  checkOutput("s239_white_cr", 32'(video), pix(721, 512));
      if (k == 240)  checkOutput("s240_yellow_cb", 32'(video), pix(674, 176));
      if (k == 1919) checkOutput("s1919_black_cr", 32'(video), pix(64, 512));
      if (k == 1920) begin
        checkOutput("s1920_fvht", 32'(fvht), 32'h2);
        checkOutput("s1920_blank", 32'(video), pix(64, 512));
      end
      if (k == H_T) begin
        checkOutput("line1_fvht", 32'(fvht), 32'h0);
        checkOutput("line1_video", 32'(video), pix(721, 512));
      end
    end

    $display("[TB] full frames");
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end while (!fvht[0] && n < LIMIT);
    checkOutput("frame1_reached", 32'(n < LIMIT), 32'h1);
    checkOutput("frame_cnt_1", 32'(frame_cnt), 32'h1);
    n      = 0;
    vcount = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
      if (fvht[2]) vcount++;
    end while (!fvht[0] && n < LIMIT);
    checkOutput("frame_period", 32'(n), 32'(H_T * V_T));
    checkOutput("v_blank_samples", 32'(vcount), 32'((V_T - V_A) * H_T));
    checkOutput("frame_cnt_2", 32'(frame_cnt), 32'h2);

    $display("[TB] cen one cycle in three");
    for (int i = 0; i < 3 * H_T; i++) applyStimulus(i % 3 == 0, 1'b1, 1'b0);

    $display("[TB] run dropped mid-frame");
    n = 0;
    while (!(m_v == 1 && m_h == 500) && n < LIMIT) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      n++;
    end while (!fvht[0] && n < LIMIT);
    checkOutput("freeze_reached", 32'(n < LIMIT), 32'h1);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("freeze_fvht", 32'(fvht), 32'h1);
    checkOutput("freeze_video", 32'(video), pix(721, 512));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("resume_first_fvht", 32'(fvht), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("resume_h1_fvht", 32'(fvht), 32'h0);

    $display("[TB] pattern select changed mid-frame");
    n = 0;
    while (m_v != 1 && n < LIMIT) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      n++;
    end while (!fvht[0] && n < LIMIT);
    checkOutput("sel_frame_reached", 32'(n < LIMIT), 32'h1);
`ifdef VID_PATGEN_RAMP_EN
    checkOutput("ramp_s0", 32'(video), pix(64, 512));
`else
    checkOutput("bars_s0", 32'(video), pix(721, 512));
`endif
    for (int i = 1; i < H_A; i++) applyStimulus(1'b1, 1'b1, 1'b1);
`ifdef VID_PATGEN_RAMP_EN
    checkOutput("ramp_s1919_max", 32'(video[19:10] <= 10'd939), 32'h1);
`else
    checkOutput("bars_s1919", 32'(video), pix(64, 512));
`endif

    $display("[TB] async reset mid-line");
    repeat (100) applyStimulus(1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_fvht", 32'(fvht), 32'h0);
    checkOutput("async_rst_video", 32'(video), pix(64, 512));
    checkOutput("async_rst_frame", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_fvht", 32'(fvht), 32'h1);
    checkOutput("post_rst_video", 32'(video), pix(721, 512));
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
